transport_rx: RTL and testbench
===============================

Name: transport_rx

Overview:
Receive side of the transport layer; the inverse of the transport packetizer. It consumes the incoming packet byte stream, parses the header byte, extracts 16-bit control words or audio samples (MSB byte first), and presents them to the application with a one-cycle strobe. It sits between the link/physical receive path and the call-control and audio-playback logic.

Parameters:
PKT_BYTES, 16, total bytes per packet including header
AUD_SAMPLES, 7, 16-bit audio samples per audio packet (bytes 1..14); remaining byte(s) are padding
CTRL_WORDS, 1, 16-bit control words per control packet (bytes 1..2); remaining bytes are padding

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
byte_in  in  8  received packet byte
byte_valid  in  1  byte_in is valid this cycle; accepted on the rising edge where high
cmd  out  2  type of current data word: 2'b01 control, 2'b10 audio, 2'b00 idle
data  out  16  extracted word; held until the next word
data_valid  out  1  one-cycle strobe: data/cmd hold a new word
pkt_done  out  1  one-cycle strobe: last byte of a packet accepted
pkt_error  out  1  one-cycle strobe: header type invalid; packet discarded
busy  out  1  high while inside a packet (after header, before last byte)

Behaviour:
- Reset (synchronous, active-high) clears every output to 0 (cmd=00, data=0, all strobes 0, busy=0), the state to HDR, and all counters to 0. Reset mid-packet discards the partial packet; no strobe is emitted for it.
- Header byte: bits[7:6] give the type: 01 control, 10 audio, 00/11 invalid. Bits[5:0] are ignored.
- Byte counter byte_cnt (width clog2(PKT_BYTES)) increments on each accepted byte. It wraps to 0 after PKT_BYTES-1.
- Cycles with byte_valid=0 are stalls: no state or counter change, and strobes stay low.
- States:
  - HDR: wait for a byte. Valid type -> HI, latch type, busy=1. Invalid type -> DROP, pkt_error pulses the next cycle, busy=1.
  - HI: latch byte into data_hi -> LO.
  - LO: on accept, data <= {data_hi, byte_in} and cmd <= type. data_valid pulses for the cycle after the accept. If words_left>0 -> HI, else -> PAD.
  - PAD: accept and ignore bytes until byte_cnt==PKT_BYTES-1.
  - DROP: same as PAD, but for an invalid packet.
- words_left is loaded with AUD_SAMPLES or CTRL_WORDS at the header. If PAD has zero bytes to consume, LO on the last byte goes directly to HDR.
- On acceptance of byte index PKT_BYTES-1 in any state: next state HDR; pkt_done pulses the next cycle, including for dropped packets; busy drops the next cycle.
- Latency: data_valid/pkt_done/pkt_error are registered, so they appear 1 cycle after the triggering byte's accept edge.
- cmd returns to 00 on the cycle after pkt_done. data holds its last value.
- Back-to-back packets with no idle cycle are legal: a header accepted the cycle after the last byte is parsed normally.
- No backpressure: the downstream block must accept one word per data_valid. Minimum word spacing is 2 cycles.
- Elaboration check: 1+2*AUD_SAMPLES <= PKT_BYTES and 1+2*CTRL_WORDS <= PKT_BYTES.

Decomposition:
- Shared package (transport_pkg): the type codes TYPE_CTRL=2'b01 and TYPE_AUDIO=2'b10, the header masks, and the PKT_BYTES default.
- The packetizer and this block must both use transport_pkg.
- No sub-module: a single FSM plus counters and the output register.

Test Plan:
- Control packet 40,12,34,00x13, contiguous -> one data_valid with cmd=01, data=0x1234; pkt_done 1 cycle after the 16th byte; busy high from the cycle after the header through the last byte.
- Audio packet 80, then 0x0001..0x0007 as hi/lo byte pairs, then 1 pad byte -> seven data_valid strobes, cmd=10, data=0x0001..0x0007 in order; single pkt_done.
- Same audio packet with byte_valid dropped for 3 cycles between bytes -> identical outputs; strobes never repeat during stalls.
- Bad header C0 + 15 bytes, then a valid control packet 40,AB,CD,... -> pkt_error once, pkt_done once, no data_valid; then data=0xABCD with cmd=01.
- Reset asserted after byte 5 of an audio packet, then a fresh control packet -> no pkt_done for the partial packet; control word parsed correctly.
- Two control packets back-to-back with no gap -> two data_valid strobes and two pkt_done strobes, 16 cycles apart.

Source files
------------

// File: rtl/transport_pkg.sv
// Shared transport-layer definitions: header type codes, header field masks and packet geometry.
package transport_pkg;

  localparam logic [1:0] TYPE_IDLE  = 2'b00;
  localparam logic [1:0] TYPE_CTRL  = 2'b01;
  localparam logic [1:0] TYPE_AUDIO = 2'b10;

  localparam logic [7:0] HDR_TYPE_MASK  = 8'hC0;
  localparam int         HDR_TYPE_SHIFT = 6;

  localparam int PKT_BYTES_DEF = 16;

  function automatic logic [1:0] hdrType(input logic [7:0] hdr);
    logic [7:0] masked;
    masked = hdr & HDR_TYPE_MASK;
    return 2'(masked >> HDR_TYPE_SHIFT);
  endfunction

endpackage

// File: rtl/transport_rx.sv
// Transport receive: parses fixed-size packets, emits 16-bit control/audio words MSB byte first.
// All strobes registered, one cycle after the triggering byte; no backpressure, stalls via byte_valid.
module transport_rx
  import transport_pkg::*;
#(
  parameter int PKT_BYTES   = PKT_BYTES_DEF,
  parameter int AUD_SAMPLES = 7,
  parameter int CTRL_WORDS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [1:0]  cmd,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        pkt_done,
  output logic        pkt_error,
  output logic        busy
);

  localparam int CNT_W = $clog2(PKT_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_BYTES - 1);

  if (1 + 2 * AUD_SAMPLES > PKT_BYTES) begin : gBadAudio
    $error("transport_rx: audio payload does not fit in PKT_BYTES");
  end
  if (1 + 2 * CTRL_WORDS > PKT_BYTES) begin : gBadCtrl
    $error("transport_rx: control payload does not fit in PKT_BYTES");
  end

  typedef enum logic [2:0] {
    HDR,
    HI,
    LO,
    PAD,
    DROP
  } rxState_e;

  rxState_e         state;
  logic [CNT_W-1:0] byteCnt;
  logic [CNT_W-1:0] wordsLeft;
  logic [7:0]       dataHi;
  logic [1:0]       pktType;
  logic [1:0]       hdrTypeNow;
  logic             lastByte;

  assign hdrTypeNow = hdrType(byte_in);
  assign lastByte   = (byteCnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR;
      byteCnt    <= '0;
      wordsLeft  <= '0;
      dataHi     <= '0;
      pktType    <= TYPE_IDLE;
      cmd        <= TYPE_IDLE;
      data       <= '0;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_error  <= 1'b0;
      // cmd falls back to idle once the packet-done strobe has been seen
      if (pkt_done) cmd <= TYPE_IDLE;

      if (byte_valid) begin
        byteCnt <= lastByte ? '0 : byteCnt + CNT_W'(1);

        unique case (state)
          HDR: begin
            busy <= 1'b1;
            if (hdrTypeNow == TYPE_CTRL || hdrTypeNow == TYPE_AUDIO) begin
              pktType   <= hdrTypeNow;
              wordsLeft <= (hdrTypeNow == TYPE_AUDIO) ? CNT_W'(AUD_SAMPLES)
                                                      : CNT_W'(CTRL_WORDS);
              state     <= HI;
            end else begin
              pkt_error <= 1'b1;
              state     <= DROP;
            end
          end
          HI: begin
            dataHi <= byte_in;
            state  <= LO;
          end
          LO: begin
            data       <= {dataHi, byte_in};
            cmd        <= pktType;
            data_valid <= 1'b1;
            wordsLeft  <= wordsLeft - CNT_W'(1);
            state      <= (wordsLeft > CNT_W'(1)) ? HI : PAD;
          end
          PAD, DROP: ;
          default: state <= HDR;
        endcase

        // The final byte closes the packet regardless of state; overrides the case above.
        if (lastByte) begin
          state    <= HDR;
          busy     <= 1'b0;
          pkt_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_transport_rx.sv
// Directed bench for transport_rx: vector table of whole packets plus hand-timed corner sequences.
module tb_transport_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [1:0]  cmd;
  logic [15:0] data;
  logic        data_valid;
  logic        pkt_done;
  logic        pkt_error;
  logic        busy;

  transport_rx dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .cmd        (cmd),
    .data       (data),
    .data_valid (data_valid),
    .pkt_done   (pkt_done),
    .pkt_error  (pkt_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] dvDat[$];
  logic [1:0]  dvCmd[$];
  int          dvCyc[$];
  int          doneCyc[$];
  int          errCnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        dvDat.push_back(data);
        dvCmd.push_back(cmd);
        dvCyc.push_back(cyc);
      end
      if (pkt_done) doneCyc.push_back(cyc);
      if (pkt_error) errCnt = errCnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic putByte(input logic [7:0] b, input int stall);
    if (stall > 0) begin
      byte_valid = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  // Header, nW words (first word in the top 16 bits of wd), then 0xEE padding to 16 bytes.
  task automatic sendPkt(input logic [7:0] hdr, input logic [111:0] wd, input int nW,
                         input int stall);
    logic [15:0] w;
    putByte(hdr, 0);
    for (int i = 0; i < nW; i++) begin
      w = wd[16*(6-i) +: 16];
      putByte(w[15:8], stall);
      putByte(w[7:0], stall);
    end
    for (int i = 1 + 2 * nW; i < 16; i++) putByte(8'hEE, stall);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [7:0]   hdr;
    logic [111:0] wd;
    int           nW;
    int           stall;
    int           expDv;
    logic [1:0]   expCmd;
    int           expErr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0]  ctrlBytes [16];
    logic [15:0] heldData;
    logic [15:0] w;
    int baseDv, baseDone, baseErr;

    vecs[0] = '{hdr:8'h40, wd:{16'h1234, 96'h0}, nW:1, stall:0, expDv:1, expCmd:2'b01, expErr:0};
    vecs[1] = '{hdr:8'h80, wd:{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007},
                nW:7, stall:0, expDv:7, expCmd:2'b10, expErr:0};
    vecs[2] = '{hdr:8'h80, wd:{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007},
                nW:7, stall:3, expDv:7, expCmd:2'b10, expErr:0};
    vecs[3] = '{hdr:8'hC0, wd:{7{16'h5AA5}}, nW:7, stall:0, expDv:0, expCmd:2'b00, expErr:1};
    vecs[4] = '{hdr:8'h40, wd:{16'hABCD, 96'h0}, nW:1, stall:0, expDv:1, expCmd:2'b01, expErr:0};
    vecs[5] = '{hdr:8'h00, wd:{16'h1234, 96'h0}, nW:1, stall:1, expDv:0, expCmd:2'b00, expErr:1};
    vecs[6] = '{hdr:8'h7F, wd:{16'hBEEF, 96'h0}, nW:1, stall:2, expDv:1, expCmd:2'b01, expErr:0};
    vecs[7] = '{hdr:8'hBF, wd:{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777},
                nW:7, stall:1, expDv:7, expCmd:2'b10, expErr:0};

    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", cmd, 2'b00);
    chk("rst_data", data, 16'h0000);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_done", pkt_done, 1'b0);
    chk("rst_err", pkt_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    idle(2);

    // Cycle-exact control packet: strobe latency, busy window, cmd return to idle.
    for (int i = 0; i < 16; i++) ctrlBytes[i] = 8'h00;
    ctrlBytes[0] = 8'h40;
    ctrlBytes[1] = 8'h12;
    ctrlBytes[2] = 8'h34;
    for (int i = 0; i < 16; i++) begin
      putByte(ctrlBytes[i], 0);
      chk($sformatf("t_busy_%0d", i), busy, (i < 15) ? 1'b1 : 1'b0);
      chk($sformatf("t_dv_%0d", i), data_valid, (i == 2) ? 1'b1 : 1'b0);
      chk($sformatf("t_done_%0d", i), pkt_done, (i == 15) ? 1'b1 : 1'b0);
      chk($sformatf("t_err_%0d", i), pkt_error, 1'b0);
      if (i == 2) begin
        chk("t_data", data, 16'h1234);
        chk("t_cmd", cmd, 2'b01);
      end
      if (i == 15) chk("t_cmd_at_done", cmd, 2'b01);
    end
    idle(1);
    chk("t_cmd_after_done", cmd, 2'b00);
    chk("t_done_once", pkt_done, 1'b0);
    chk("t_data_hold", data, 16'h1234);
    heldData = 16'h1234;
    idle(2);

    for (int v = 0; v < 8; v++) begin
      baseDv   = dvDat.size();
      baseDone = doneCyc.size();
      baseErr  = errCnt;
      sendPkt(vecs[v].hdr, vecs[v].wd, vecs[v].nW, vecs[v].stall);
      idle(3);
      chk($sformatf("v%0d_dv_count", v), dvDat.size() - baseDv, vecs[v].expDv);
      chk($sformatf("v%0d_done_count", v), doneCyc.size() - baseDone, 1);
      chk($sformatf("v%0d_err_count", v), errCnt - baseErr, vecs[v].expErr);
      for (int k = 0; k < vecs[v].expDv && baseDv + k < dvDat.size(); k++) begin
        w = vecs[v].wd[16*(6-k) +: 16];
        chk($sformatf("v%0d_word%0d", v, k), dvDat[baseDv+k], w);
        chk($sformatf("v%0d_cmd%0d", v, k), dvCmd[baseDv+k], vecs[v].expCmd);
      end
      if (vecs[v].expDv > 0) heldData = vecs[v].wd[16*(7-vecs[v].expDv) +: 16];
      chk($sformatf("v%0d_data_hold", v), data, heldData);
      chk($sformatf("v%0d_cmd_idle", v), cmd, 2'b00);
      chk($sformatf("v%0d_busy_idle", v), busy, 1'b0);
    end

    // Reset in the middle of an audio packet discards it without a done strobe.
    baseDone = doneCyc.size();
    putByte(8'h80, 0);
    putByte(8'h00, 0);
    putByte(8'h01, 0);
    putByte(8'h00, 0);
    putByte(8'h02, 0);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_data", data, 16'h0000);
    chk("mr_cmd", cmd, 2'b00);
    chk("mr_done", pkt_done, 1'b0);
    reset = 1'b0;
    idle(2);
    chk("mr_no_done", doneCyc.size() - baseDone, 0);
    baseDv   = dvDat.size();
    baseDone = doneCyc.size();
    sendPkt(8'h40, {16'hC0DE, 96'h0}, 1, 0);
    idle(3);
    chk("mr_dv_count", dvDat.size() - baseDv, 1);
    chk("mr_done_count", doneCyc.size() - baseDone, 1);
    chk("mr_data_after", data, 16'hC0DE);
    if (dvDat.size() > baseDv) chk("mr_cmd_word", dvCmd[baseDv], 2'b01);

    // Back-to-back control packets with no idle cycle between them.
    baseDv   = dvDat.size();
    baseDone = doneCyc.size();
    sendPkt(8'h40, {16'h0A0B, 96'h0}, 1, 0);
    sendPkt(8'h40, {16'h0C0D, 96'h0}, 1, 0);
    idle(3);
    chk("b2b_dv_count", dvDat.size() - baseDv, 2);
    chk("b2b_done_count", doneCyc.size() - baseDone, 2);
    if (dvDat.size() >= baseDv + 2) begin
      chk("b2b_word0", dvDat[baseDv], 16'h0A0B);
      chk("b2b_word1", dvDat[baseDv+1], 16'h0C0D);
      chk("b2b_dv_gap", dvCyc[baseDv+1] - dvCyc[baseDv], 16);
    end
    if (doneCyc.size() >= baseDone + 2)
      chk("b2b_done_gap", doneCyc[baseDone+1] - doneCyc[baseDone], 16);
    chk("b2b_busy_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
